// File: rtl/mac_pkg.sv
// Shared constants and saturation helpers for the int8 MAC datapath.
// Used by mac_mul_stage and mac_accumulator.
package mac_pkg;

  localparam int ACT_W         = 8;
  localparam int PROD_W        = 16;
  localparam int SUM_W_DEFAULT = 20;

  // Largest signed value representable in w bits (low 32 bits).
  function automatic logic [31:0] sat_max(input int w);
    logic [63:0] v;
    v = (64'd1 << (w - 1)) - 64'd1;
    return v[31:0];
  endfunction

  // Smallest signed value representable in w bits (low 32 bits).
  function automatic logic [31:0] sat_min(input int w);
    logic [63:0] v;
    v = ~((64'd1 << (w - 1)) - 64'd1);
    return v[31:0];
  endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// P1 of the MAC pipeline: registers act*wgt with its valid/last flags.
// Stalls only when it holds a vector's last product and the result cannot drain.
module mac_mul_stage
  import mac_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     in_valid_i,
  input  logic signed [ACT_W-1:0]  act_i,
  input  logic signed [ACT_W-1:0]  wgt_i,
  input  logic                     in_last_i,
  input  logic                     out_valid_i,
  input  logic                     out_ready_i,
  output logic                     in_ready_o,
  output logic                     p1_v_o,
  output logic                     p1_last_o,
  output logic                     p1_adv_o,
  output logic signed [PROD_W-1:0] p1_prod_o
);

  logic                     p1_v_q;
  logic                     p1_last_q;
  logic signed [PROD_W-1:0] p1_prod_q;
  logic signed [PROD_W-1:0] prod_d;
  logic                     accept;

  assign prod_d     = PROD_W'(act_i) * PROD_W'(wgt_i);
  assign p1_adv_o   = !(p1_last_q && out_valid_i && !out_ready_i);
  assign in_ready_o = !clr_i && (!p1_v_q || p1_adv_o);
  assign accept     = in_valid_i && in_ready_o;

  assign p1_v_o    = p1_v_q;
  assign p1_last_o = p1_last_q;
  assign p1_prod_o = p1_prod_q;

  // Capture a new product on accept; drop valid once it has moved on.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p1_v_q    <= 1'b0;
      p1_last_q <= 1'b0;
      p1_prod_q <= '0;
    end else if (clr_i) begin
      p1_v_q    <= 1'b0;
    end else if (accept) begin
      p1_v_q    <= 1'b1;
      p1_last_q <= in_last_i;
      p1_prod_q <= prod_d;
    end else if (p1_adv_o) begin
      p1_v_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Signed int8 x int8 MAC over a vector: accumulate stage plus output register.
// Build option ACC_SAT_EN: clamp the sum on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_W_DEFAULT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [ACT_W-1:0]     act,
  input  logic signed [ACT_W-1:0]     wgt,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [SUM_WIDTH-1:0] sum_accum,
  output logic                        ovf,
  output logic [CNT_WIDTH-1:0]        elem_cnt
);

  logic                     p1_v;
  logic                     p1_last;
  logic                     p1_adv;
  logic signed [PROD_W-1:0] p1_prod;

  logic                 first_q;
  logic [SUM_WIDTH-1:0] acc_q, acc_d, acc_base;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
  logic                 ovf_q, ovf_d, ovf_base;
  logic [SUM_WIDTH:0]   sum_wide;
  logic                 add_ovf;
  logic                 step;

  logic                 ov_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic                 osat_q;
  logic [CNT_WIDTH-1:0] ocnt_q;

  mac_mul_stage u_mul (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .act_i       (act),
    .wgt_i       (wgt),
    .in_last_i   (in_last),
    .out_valid_i (ov_q),
    .out_ready_i (out_ready),
    .in_ready_o  (in_ready),
    .p1_v_o      (p1_v),
    .p1_last_o   (p1_last),
    .p1_adv_o    (p1_adv),
    .p1_prod_o   (p1_prod)
  );

  assign step     = p1_v && p1_adv && !clr;
  assign acc_base = first_q ? '0 : acc_q;
  assign cnt_base = first_q ? '0 : cnt_q;
  assign ovf_base = first_q ? 1'b0 : ovf_q;

  // One extra bit exposes signed overflow of the SUM_WIDTH add.
  assign sum_wide = {acc_base[SUM_WIDTH-1], acc_base}
                  + {{(SUM_WIDTH+1-PROD_W){p1_prod[PROD_W-1]}}, p1_prod};
  assign add_ovf  = sum_wide[SUM_WIDTH] ^ sum_wide[SUM_WIDTH-1];
  assign ovf_d    = ovf_base | add_ovf;
  assign cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);

`ifdef ACC_SAT_EN
  localparam logic [31:0] SMAX32 = sat_max(SUM_WIDTH);
  localparam logic [31:0] SMIN32 = sat_min(SUM_WIDTH);
  // Clamp toward the true sign of the unbounded sum.
  assign acc_d = !add_ovf ? sum_wide[SUM_WIDTH-1:0]
               : sum_wide[SUM_WIDTH] ? SMIN32[SUM_WIDTH-1:0]
               : SMAX32[SUM_WIDTH-1:0];
`else
  assign acc_d = sum_wide[SUM_WIDTH-1:0];
`endif

  // Partial-sum register; restarts from zero after each vector or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      first_q <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (step) begin
      first_q <= p1_last;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result register; a new result may replace one draining this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      sum_q  <= '0;
      osat_q <= 1'b0;
      ocnt_q <= '0;
    end else if (step && p1_last) begin
      ov_q   <= 1'b1;
      sum_q  <= acc_d;
      osat_q <= ovf_d;
      ocnt_q <= cnt_d;
    end else if (out_ready) begin
      ov_q   <= 1'b0;
    end
  end

  assign out_valid = ov_q;
  assign sum_accum = sum_q;
  assign ovf       = osat_q;
  assign elem_cnt  = ocnt_q;

endmodule
